// File: rtl/bmp_rgb565_unpack.sv
// Parses a 24-bit BMP header from a 16-bit word stream, skips to the pixel array,
// drops row padding and emits one RGB565 strobe per pixel in file order.
module bmp_rgb565_unpack #(
    parameter int unsigned MAX_W = 1920,
    parameter int unsigned MAX_H = 1080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [15:0] img_width,
    output logic [15:0] img_height,
    output logic        hdr_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SKIP,
        S_PIXEL,
        S_PAD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_nxt;

    logic [7:0]  pend_byte;
    logic        pend_valid;
    logic        byte_valid;
    logic [7:0]  cur_byte;

    logic [15:0] bcnt;
    logic [7:0]  sig0_q, sig1_q;
    logic [31:0] offset_q, width_q, height_q, comp_q;
    logic [15:0] bpp_q;
    logic [1:0]  hdr_code;

    logic [1:0]  phase;
    logic [4:0]  blue_q;
    logic [5:0]  green_q;
    logic [10:0] col_cnt;
    logic [1:0]  pad_cnt;
    logic [21:0] pix_cnt, pix_total;
    logic        row_end, last_pix;

    // The high byte is used in the in_valid cycle, the latched low byte the cycle after.
    assign byte_valid = in_valid | pend_valid;
    assign cur_byte   = in_valid ? in_data[15:8] : pend_byte;

    assign pix_total = {11'd0, width_q[10:0]} * {11'd0, height_q[10:0]};
    assign row_end   = (col_cnt + 11'd1) == width_q[10:0];
    assign last_pix  = (pix_cnt + 22'd1) == pix_total;

    always_comb begin
        hdr_code = 2'd0;
        if (sig0_q != 8'h42 || sig1_q != 8'h4D)
            hdr_code = 2'd1;
        else if (bpp_q != 16'd24 || comp_q != 32'd0)
            hdr_code = 2'd2;
        else if (offset_q < 32'd54 || offset_q[31:16] != 16'd0 ||
                 width_q == 32'd0 || height_q == 32'd0 ||
                 width_q > MAX_W || height_q > MAX_H)
            hdr_code = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_HEADER;
        end else if (byte_valid) begin
            case (state)
                S_HEADER:
                    if (bcnt == 16'd53) begin
                        if (hdr_code != 2'd0)
                            state_nxt = S_ERROR;
                        else if (offset_q > 32'd54)
                            state_nxt = S_SKIP;
                        else
                            state_nxt = S_PIXEL;
                    end
                S_SKIP:
                    if (bcnt == offset_q[15:0] - 16'd1)
                        state_nxt = S_PIXEL;
                S_PIXEL:
                    if (phase == 2'd2) begin
                        if (last_pix)
                            state_nxt = S_DONE;
                        else if (row_end && width_q[1:0] != 2'd0)
                            state_nxt = S_PAD;
                    end
                S_PAD:
                    if (pad_cnt == width_q[1:0] - 2'd1)
                        state_nxt = S_PIXEL;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == S_HEADER) || (state == S_SKIP) ||
               (state == S_PIXEL)  || (state == S_PAD);
        done = (state == S_DONE);
    end

    // Header fields are shifted in from the top so four little-endian bytes land in order.
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            pend_byte  <= 8'd0;
            pend_valid <= 1'b0;
            bcnt       <= 16'd0;
            sig0_q     <= 8'd0;
            sig1_q     <= 8'd0;
            offset_q   <= 32'd0;
            width_q    <= 32'd0;
            height_q   <= 32'd0;
            comp_q     <= 32'd0;
            bpp_q      <= 16'd0;
            phase      <= 2'd0;
            blue_q     <= 5'd0;
            green_q    <= 6'd0;
            col_cnt    <= 11'd0;
            pad_cnt    <= 2'd0;
            pix_cnt    <= 22'd0;
            out_valid  <= 1'b0;
            out_data   <= 16'd0;
            img_width  <= 16'd0;
            img_height <= 16'd0;
            hdr_valid  <= 1'b0;
            err        <= 2'd0;
        end else begin
            pend_valid <= in_valid;
            if (in_valid)
                pend_byte <= in_data[7:0];
            out_valid <= 1'b0;
            if (byte_valid) begin
                case (state)
                    S_HEADER: begin
                        bcnt <= bcnt + 16'd1;
                        if (bcnt == 16'd0) sig0_q <= cur_byte;
                        if (bcnt == 16'd1) sig1_q <= cur_byte;
                        if (bcnt >= 16'd10 && bcnt <= 16'd13) offset_q <= {cur_byte, offset_q[31:8]};
                        if (bcnt >= 16'd18 && bcnt <= 16'd21) width_q  <= {cur_byte, width_q[31:8]};
                        if (bcnt >= 16'd22 && bcnt <= 16'd25) height_q <= {cur_byte, height_q[31:8]};
                        if (bcnt >= 16'd28 && bcnt <= 16'd29) bpp_q    <= {cur_byte, bpp_q[15:8]};
                        if (bcnt >= 16'd30 && bcnt <= 16'd33) comp_q   <= {cur_byte, comp_q[31:8]};
                        if (bcnt == 16'd53) begin
                            if (hdr_code == 2'd0) begin
                                hdr_valid  <= 1'b1;
                                img_width  <= width_q[15:0];
                                img_height <= height_q[15:0];
                            end else begin
                                err <= hdr_code;
                            end
                        end
                    end
                    S_SKIP:
                        bcnt <= bcnt + 16'd1;
                    S_PIXEL: begin
                        case (phase)
                            2'd0: begin
                                blue_q <= cur_byte[7:3];
                                phase  <= 2'd1;
                            end
                            2'd1: begin
                                green_q <= cur_byte[7:2];
                                phase   <= 2'd2;
                            end
                            default: begin
                                out_valid <= 1'b1;
                                out_data  <= {cur_byte[7:3], green_q, blue_q};
                                phase     <= 2'd0;
                                pix_cnt   <= pix_cnt + 22'd1;
                                pad_cnt   <= 2'd0;
                                col_cnt   <= row_end ? 11'd0 : col_cnt + 11'd1;
                            end
                        endcase
                    end
                    S_PAD:
                        pad_cnt <= pad_cnt + 2'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bmp_rgb565_unpack.sv
// Randomized scoreboard bench: builds BMP byte images, predicts pixels/errors from the
// file-format rules, and a monitor pops expectations whenever out_valid fires.
module tb_bmp_rgb565_unpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic        hdr_valid;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  file_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic [1:0]  exp_err;
    logic [15:0] exp_w, exp_h;

    bmp_rgb565_unpack #(.MAX_W(1920), .MAX_H(1080)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .img_width(img_width),
        .img_height(img_height), .hdr_valid(hdr_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Every strobe must match the oldest predicted pixel; done must rise exactly with the last one.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pixel: got %h expected no strobe", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("pixel", out_data, mon_exp);
                checkOutput("done_with_last", done, exp_q.size() == 0);
            end
        end
    end

    task automatic buildFile(input logic [7:0] s1, input logic [31:0] offset, input logic [31:0] w,
                             input logic [31:0] h, input logic [15:0] bpp, input logic [31:0] comp,
                             input bit fixed_pix, input logic [7:0] fb, input logic [7:0] fg,
                             input logic [7:0] fr, input logic [7:0] gap);
        logic [7:0] hdr[54];
        logic [7:0] b, g, r;
        int pad;
        file_q.delete();
        for (int i = 0; i < 54; i++) hdr[i] = 8'($urandom);
        hdr[0] = 8'h42;
        hdr[1] = s1;
        for (int i = 0; i < 4; i++) begin
            hdr[10 + i] = offset[8*i +: 8];
            hdr[18 + i] = w[8*i +: 8];
            hdr[22 + i] = h[8*i +: 8];
            hdr[30 + i] = comp[8*i +: 8];
        end
        hdr[28] = bpp[7:0];
        hdr[29] = bpp[15:8];
        if (s1 != 8'h4D) exp_err = 2'd1;
        else if (bpp != 16'd24 || comp != 0) exp_err = 2'd2;
        else if (offset < 54 || offset > 65535 || w == 0 || h == 0 || w > 1920 || h > 1080) exp_err = 2'd3;
        else exp_err = 2'd0;
        exp_w = (exp_err == 2'd0) ? w[15:0] : 16'd0;
        exp_h = (exp_err == 2'd0) ? h[15:0] : 16'd0;
        for (int i = 0; i < 54; i++) file_q.push_back(hdr[i]);
        if (exp_err == 2'd0) begin
            for (int i = 54; i < int'(offset); i++) file_q.push_back(gap);
            pad = (4 - ((3 * int'(w)) % 4)) % 4;
            for (int y = 0; y < int'(h); y++) begin
                for (int x = 0; x < int'(w); x++) begin
                    b = fixed_pix ? fb : 8'($urandom);
                    g = fixed_pix ? fg : 8'($urandom);
                    r = fixed_pix ? fr : 8'($urandom);
                    file_q.push_back(b);
                    file_q.push_back(g);
                    file_q.push_back(r);
                    exp_q.push_back({r[7:3], g[7:2], b[7:3]});
                end
                for (int p = 0; p < pad; p++) file_q.push_back(8'($urandom));
            end
        end
        for (int i = 0; i < 10; i++) file_q.push_back(8'($urandom));
    endtask

    task automatic applyStimulus(input int nbytes);
        logic [7:0] hi, lo;
        for (int i = 0; i < nbytes; i += 2) begin
            hi = file_q[i];
            lo = (i + 1 < file_q.size()) ? file_q[i + 1] : 8'h00;
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = {hi, lo};
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic startPulse();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitEnd(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done || err != 2'd0) && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got done=%0b err=%0d expected completion", name, done, err);
        end
        checkOutput({name, "_done"}, done, exp_err == 2'd0);
        checkOutput({name, "_err"}, err, exp_err);
        checkOutput({name, "_hdr_valid"}, hdr_valid, exp_err == 2'd0);
        checkOutput({name, "_width"}, img_width, exp_w);
        checkOutput({name, "_height"}, img_height, exp_h);
        checkOutput({name, "_busy"}, busy, 1'b0);
        checkOutput({name, "_missing_pixels"}, exp_q.size(), 0);
    endtask

    task automatic runFile(input string name, input logic [7:0] s1, input logic [31:0] offset,
                           input logic [31:0] w, input logic [31:0] h, input logic [15:0] bpp,
                           input logic [31:0] comp, input bit fixed_pix, input logic [7:0] fb,
                           input logic [7:0] fg, input logic [7:0] fr, input logic [7:0] gap);
        buildFile(s1, offset, w, h, bpp, comp, fixed_pix, fb, fg, fr, gap);
        startPulse();
        applyStimulus(file_q.size());
        repeat (4) @(posedge clk);
        waitEnd(name);
    endtask

    task automatic checkAllClear(input string name);
        checkOutput({name, "_out_valid"}, out_valid, 1'b0);
        checkOutput({name, "_out_data"}, out_data, 16'd0);
        checkOutput({name, "_hdr_valid"}, hdr_valid, 1'b0);
        checkOutput({name, "_width"}, img_width, 16'd0);
        checkOutput({name, "_height"}, img_height, 16'd0);
        checkOutput({name, "_done"}, done, 1'b0);
        checkOutput({name, "_err"}, err, 2'd0);
    endtask

    initial begin
        #600000;
        errors++;
        $display("[TB] FAIL watchdog: got no finish expected end of run");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkAllClear("reset");
        checkOutput("reset_busy", busy, 1'b0);

        // Words arriving before any start must be ignored.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 16'h424D;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_hdr_valid", hdr_valid, 1'b0);

        runFile("white4x2", 8'h4D, 54, 4, 2, 16'd24, 0, 1'b1, 8'h1F, 8'hFF, 8'hF8, 8'hAA);
        runFile("red3x2",   8'h4D, 54, 3, 2, 16'd24, 0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'hAA);
        runFile("gap1x1",   8'h4D, 58, 1, 1, 16'd24, 0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hAA);

        runFile("badsig", 8'h4E, 54, 4, 2, 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput("badsig_err_held", err, 2'd1);
        checkOutput("badsig_hdr_held", hdr_valid, 1'b0);
        startPulse();
        checkOutput("badsig_err_cleared", err, 2'd0);
        checkOutput("badsig_busy_after_start", busy, 1'b1);

        runFile("bpp16",   8'h4D, 54, 4, 2, 16'd16, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);
        runFile("comp1",   8'h4D, 54, 4, 2, 16'd24, 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);
        runFile("wide",    8'h4D, 54, 2000, 2, 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);
        runFile("neg_h",   8'h4D, 54, 4, 32'hFFFF_FFFE, 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);
        runFile("low_off", 8'h4D, 40, 4, 2, 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);

        for (int t = 0; t < 6; t++) begin
            runFile("random", 8'h4D, 54 + $urandom_range(0, 5), $urandom_range(1, 7),
                    $urandom_range(1, 3), 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'($urandom));
        end

        // Abort mid-pixel with a word in the same cycle as start; that word must vanish.
        buildFile(8'h4D, 54, 4, 2, 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);
        startPulse();
        applyStimulus(60);
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h424D;
        exp_q.delete();
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        checkAllClear("abort");
        checkOutput("abort_busy", busy, 1'b1);
        buildFile(8'h4D, 54, 2, 1, 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);
        applyStimulus(file_q.size());
        repeat (4) @(posedge clk);
        waitEnd("after_abort");

        buildFile(8'h4D, 54, 5, 3, 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hAA);
        startPulse();
        applyStimulus(70);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midparse_hdr_valid", hdr_valid, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        checkAllClear("midreset");
        checkOutput("midreset_busy", busy, 1'b0);
        rst_n = 1'b1;
        runFile("recover", 8'h4D, 55, 2, 2, 16'd24, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
